// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and instruction
// field positions used by the IR, register file and ALU stages.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Read-port operand select: zero register, same-edge write bypass, else stored.
module regfile_bypass_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] stored,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] fwd
);

  always_comb begin
    fwd = stored;
    if (rd_idx == '0)
      fwd = '0;
    else if (reg_write && (write_reg == rd_idx))
      fwd = write_data;
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS register file: two registered read ports with write-first
// bypass, one synchronous write port, hardwired zero register, debug port.
module register_file #(
  parameter int unsigned DATA_W     = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W     = mips_pkg::ADDR_W,
  parameter bit          INIT_INDEX = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ReadEn,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              ReadValid,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;

  regfile_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux1 (
    .rd_idx     (ReadReg1),
    .stored     (regs[ReadReg1]),
    .reg_write  (RegWrite),
    .write_reg  (WriteReg),
    .write_data (WriteData),
    .fwd        (fwd1)
  );

  regfile_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux2 (
    .rd_idx     (ReadReg2),
    .stored     (regs[ReadReg2]),
    .reg_write  (RegWrite),
    .write_reg  (WriteReg),
    .write_data (WriteData),
    .fwd        (fwd2)
  );

  // Entry 0 is reset to zero and never written, so it stays zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= INIT_INDEX ? DATA_W'(i) : '0;
    end else if (RegWrite && (WriteReg != '0)) begin
      regs[WriteReg] <= WriteData;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      A         <= '0;
      B         <= '0;
      ReadValid <= 1'b0;
    end else begin
      ReadValid <= ReadEn;
      if (ReadEn) begin
        A <= fwd1;
        B <= fwd2;
      end
    end
  end

  always_comb begin
    DbgData = regs[DbgAddr];
    if (DbgAddr == '0)
      DbgData = '0;
  end

endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against a behavioural register-array model.
module tb_register_file;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ReadEn = 1'b0;
  logic [4:0]  ReadReg1 = '0;
  logic [4:0]  ReadReg2 = '0;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteReg = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] A;
  logic [31:0] B;
  logic        ReadValid;
  logic [4:0]  DbgAddr = '0;
  logic [31:0] DbgData;

  register_file #(.DATA_W(32), .ADDR_W(5), .INIT_INDEX(1'b1)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ReadEn    (ReadEn),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .A         (A),
    .B         (B),
    .ReadValid (ReadValid),
    .DbgAddr   (DbgAddr),
    .DbgData   (DbgData)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  logic [31:0] m [32];
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic        exp_v;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] fwdm(input logic [4:0] r, input logic we,
                                       input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wr == r) return wd;
    return m[r];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'(i);
    exp_a = '0;
    exp_b = '0;
    exp_v = 1'b0;
  endfunction

  // Drives one cycle's inputs, steps the model at the edge, returns just after it.
  task automatic cycle(input logic re, input logic [4:0] r1, input logic [4:0] r2,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd);
    ReadEn = re; ReadReg1 = r1; ReadReg2 = r2;
    RegWrite = we; WriteReg = wr; WriteData = wd;
    @(posedge CLK);
    if (re) begin
      exp_a = fwdm(r1, we, wr, wd);
      exp_b = fwdm(r2, we, wr, wd);
    end
    exp_v = re;
    if (we && wr != 5'd0) m[wr] = wd;
    #1;
  endtask

  // Async reset between edges, spanning one edge with a write that must be dropped.
  task automatic async_reset(input logic [4:0] wr, input logic [31:0] wd);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    RegWrite = 1'b1; WriteReg = wr; WriteData = wd; ReadEn = 1'b1;
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    RegWrite = 1'b0; ReadEn = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (started && !RESET) begin
      check("A_model", A, exp_a);
      check("B_model", B, exp_b);
      check("ReadValid_model", {31'd0, ReadValid}, {31'd0, exp_v});
      check("DbgData_model", DbgData, (DbgAddr == 5'd0) ? 32'd0 : m[DbgAddr]);
    end
  end

  initial begin
    model_reset();
    #1;
    check("reset_A", A, 32'd0);
    check("reset_B", B, 32'd0);
    check("reset_valid", {31'd0, ReadValid}, 32'd0);
    #11;
    RESET = 1'b0;
    started = 1'b1;

    cycle(1, 5'd3, 5'd4, 0, 5'd0, 32'd0);
    check("first_read_A", A, 32'd3);
    check("first_read_B", B, 32'd4);
    check("first_read_valid", {31'd0, ReadValid}, 32'd1);
    DbgAddr = 5'd17; #1;
    check("dbg_17", DbgData, 32'd17);

    cycle(1, 5'd5, 5'd0, 0, 5'd0, 32'd0);
    check("hold_A0", A, 32'd5); check("hold_v0", {31'd0, ReadValid}, 32'd1);
    cycle(1, 5'd6, 5'd0, 0, 5'd0, 32'd0);
    check("hold_A1", A, 32'd6); check("hold_v1", {31'd0, ReadValid}, 32'd1);
    cycle(0, 5'd7, 5'd0, 0, 5'd0, 32'd0);
    check("hold_A2", A, 32'd6); check("hold_v2", {31'd0, ReadValid}, 32'd0);
    cycle(1, 5'd8, 5'd0, 0, 5'd0, 32'd0);
    check("hold_A3", A, 32'd8); check("hold_v3", {31'd0, ReadValid}, 32'd1);

    cycle(0, 5'd0, 5'd0, 1, 5'd2, 32'hDEAD_BEEF);
    cycle(1, 5'd2, 5'd0, 0, 5'd0, 32'd0);
    check("wr_then_rd_A", A, 32'hDEAD_BEEF);
    check("wr_then_rd_v", {31'd0, ReadValid}, 32'd1);

    DbgAddr = 5'd9; #1;
    check("dbg9_before", DbgData, 32'd9);
    cycle(1, 5'd9, 5'd9, 1, 5'd9, 32'h1234);
    check("bypass_A", A, 32'h1234);
    check("bypass_B", B, 32'h1234);
    check("dbg9_after", DbgData, 32'h1234);

    cycle(1, 5'd0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF);
    check("zero_same_edge", A, 32'd0);
    cycle(1, 5'd0, 5'd0, 0, 5'd0, 32'd0);
    check("zero_next_edge", A, 32'd0);
    DbgAddr = 5'd0; #1;
    check("dbg_zero", DbgData, 32'd0);

    cycle(1, 5'd3, 5'd4, 1, 5'd10, 32'hAA);
    DbgAddr = 5'd10; #1;
    check("dbg10_written", DbgData, 32'hAA);
    #1;
    RESET = 1'b1;
    model_reset();
    #1;
    check("async_A", A, 32'd0);
    check("async_B", B, 32'd0);
    check("async_valid", {31'd0, ReadValid}, 32'd0);
    check("async_dbg10", DbgData, 32'd10);
    RegWrite = 1'b1; WriteReg = 5'd11; WriteData = 32'h55;
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    RegWrite = 1'b0;
    DbgAddr = 5'd11; #1;
    check("write_in_reset_dropped", DbgData, 32'd11);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset(5'($urandom_range(1, 31)), $urandom);
      end else begin
        DbgAddr = 5'($urandom);
        cycle(1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
              1'($urandom), 5'($urandom), $urandom);
      end
    end

    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
